cpu_multicycle_sequencer: RTL and testbench
===========================================

Name: cpu_multicycle_sequencer

Overview:
Multi-cycle control sequencer for the LEGv8 datapath. It replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB state machine and issues per-state control strobes. It shares one unified memory port between instruction fetch and data access through a req/ack handshake. It also tracks retired instructions and flags illegal opcodes and memory timeouts.

Parameters:
CNT_W, 16, width of retire_count (wraps modulo 2^CNT_W)
MEM_TIMEOUT, 8, maximum cycles mem_req may wait for mem_ack before error (>=1)

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  begin execution; sampled only in IDLE
inst31_21  in  11  opcode field from instruction register
alu_zero  in  1  ALU zero flag, valid in EXEC
mem_ack  in  1  memory completion, one-cycle pulse
mem_req  out  1  memory access request, held until ack
mem_we  out  1  1=write (STUR), 0=read; valid with mem_req
ir_write  out  1  load instruction register
pc_write  out  1  update PC
pc_sel  out  1  0=PC+4, 1=branch target
reg_write  out  1  register file write strobe
mem_to_reg  out  1  WB source: 1=memory, 0=ALU
reg2loc  out  1  second read register select
alu_op  out  2  00 add (address), 01 pass/compare (CB), 10 R-type funct
alu_src  out  2  00 register, 01 D-offset, 10 imm12
state  out  3  current state encoding
halted  out  1  sticky, HALT executed
err_illegal  out  1  sticky, undecodable opcode
err_timeout  out  1  sticky, memory ack timeout
retire_count  out  CNT_W  retired-instruction counter

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7.
- Reset (async, rst_n=0): state=IDLE. All outputs 0, retire_count=0, class register cleared. An in-flight mem_req drops immediately.
- IDLE: start=1 -> FETCH.
- FETCH: mem_req=1, mem_we=0.
  - On mem_ack (same cycle, combinational): ir_write=1, pc_write=1, pc_sel=0 -> DECODE.
- DECODE: one cycle. Latch class from inst31_21:
  - LDUR = 11111000010
  - STUR = 11111000000
  - RTYPE = ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - ADDI = [10:1] 1001000100
  - CBZ = [10:3] 10110100
  - CBNZ = [10:3] 10110101
  - B = [10:5] 000101
  - HALT = 11111111111
  - Full-width matches take priority over prefix matches.
  - Transitions: HALT -> HALT; no match -> ERROR with err_illegal=1; otherwise -> EXEC.
- EXEC: one cycle. Outputs and transitions by class:
  - LDUR: alu_op=00, alu_src=01, reg2loc=0 -> MEM.
  - STUR: alu_op=00, alu_src=01, reg2loc=1 -> MEM.
  - RTYPE: alu_op=10, alu_src=00 -> WB.
  - ADDI: alu_op=10, alu_src=10 -> WB.
  - CBZ/CBNZ: alu_op=01, reg2loc=1. Taken (CBZ with alu_zero=1, CBNZ with alu_zero=0) gives pc_write=1, pc_sel=1. Retire -> FETCH.
  - B: pc_write=1, pc_sel=1. Retire -> FETCH.
- MEM: mem_req=1, mem_we=(class==STUR), alu_src=01.
  - On mem_ack: LDUR -> WB; STUR retires -> FETCH.
- WB: reg_write=1, mem_to_reg=(class==LDUR). Retire -> FETCH.
- Retire: retire_count increments by 1 on the transition, wrapping at 2^CNT_W. HALT is not counted.
- HALT: halted=1, all strobes 0. Stays until reset; start is ignored.
- ERROR: all strobes 0, sticky flag held. Stays until reset.
- Timeout: a wait counter clears on entry to FETCH and to MEM. If mem_ack has not arrived within the first MEM_TIMEOUT cycles of the request, the next state is ERROR with err_timeout=1 and mem_req drops.
- mem_ack outside FETCH/MEM is ignored.
- mem_req deasserts the cycle after ack, except that a WB/STUR retire re-enters FETCH and re-asserts it.
- start in any state other than IDLE is ignored.
- Ack and timeout on the same cycle: ack wins.
- Outputs are Moore on state and class, except ir_write/pc_write in FETCH, which are qualified by mem_ack.

Test Plan:
- ADD (10001011000), mem_ack on the first FETCH cycle -> states 1,2,3,5 then FETCH; reg_write=1 only in WB; retire_count=1.
- LDUR, ack 2 cycles late in FETCH and MEM -> mem_req high 3 cycles in each; WB with mem_to_reg=1; total 9 cycles; retire_count=1.
- CBZ with alu_zero=1 -> EXEC has pc_write=1, pc_sel=1. CBZ with alu_zero=0 -> pc_write=0. CBNZ mirrors this.
- Opcode 00000000000 -> ERROR (state=7), err_illegal=1; start and mem_ack ignored afterwards.
- MEM_TIMEOUT=4, no ack in FETCH -> ERROR after 4 request cycles, err_timeout=1, mem_req=0.
- rst_n low mid-MEM -> state=0 and mem_req=0 immediately, retire_count=0. HALT afterwards -> halted=1, count unchanged.

Source files
------------

// File: rtl/cpu_multicycle_sequencer_if.sv
// Control/memory-handshake bundle between the LEGv8 multi-cycle sequencer and its datapath.
// master = sequencer side, slave = datapath/memory side.
interface cpu_multicycle_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic              start;
  logic [10:0]       inst31_21;
  logic              alu_zero;
  logic              mem_ack;
  logic              mem_req;
  logic              mem_we;
  logic              ir_write;
  logic              pc_write;
  logic              pc_sel;
  logic              reg_write;
  logic              mem_to_reg;
  logic              reg2loc;
  logic [1:0]        alu_op;
  logic [1:0]        alu_src;
  logic [2:0]        state;
  logic              halted;
  logic              err_illegal;
  logic              err_timeout;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    input  start, inst31_21, alu_zero, mem_ack,
    output mem_req, mem_we, ir_write, pc_write, pc_sel, reg_write, mem_to_reg,
           reg2loc, alu_op, alu_src, state, halted, err_illegal, err_timeout,
           retire_count
  );

  modport slave (
    output start, inst31_21, alu_zero, mem_ack,
    input  mem_req, mem_we, ir_write, pc_write, pc_sel, reg_write, mem_to_reg,
           reg2loc, alu_op, alu_src, state, halted, err_illegal, err_timeout,
           retire_count
  );
endinterface

// File: rtl/cpu_multicycle_sequencer.sv
// LEGv8 multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a shared
// req/ack memory port, retire counter, and sticky halt/illegal/timeout flags.
module cpu_multicycle_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  cpu_multicycle_sequencer_if.master  bus
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_NONE  = 4'd0,
    C_LDUR  = 4'd1,
    C_STUR  = 4'd2,
    C_RTYPE = 4'd3,
    C_ADDI  = 4'd4,
    C_CBZ   = 4'd5,
    C_CBNZ  = 4'd6,
    C_B     = 4'd7,
    C_HALT  = 4'd8
  } class_t;

  state_t              r_state;
  class_t              r_class;
  logic [WAIT_W-1:0]   r_wait;
  logic [CNT_W-1:0]    r_retire;
  logic                r_halted;
  logic                r_err_illegal;
  logic                r_err_timeout;

  logic [10:0]         w_inst;
  logic                w_start;
  logic                w_ack;
  logic                w_zero;
  class_t              w_dec_class;
  logic                w_wait_done;
  logic                w_taken;

  assign w_inst      = bus.inst31_21;
  assign w_start     = bus.start;
  assign w_ack       = bus.mem_ack;
  assign w_zero      = bus.alu_zero;
  assign w_wait_done = (r_wait == WAIT_W'(MEM_TIMEOUT - 1));
  assign w_taken     = ((r_class == C_CBZ) && w_zero) || ((r_class == C_CBNZ) && !w_zero);

  // Opcode classifier: exact encodings are checked before prefix encodings.
  always_comb begin
    w_dec_class = C_NONE;
    if (w_inst == 11'b11111000010)                                   w_dec_class = C_LDUR;
    else if (w_inst == 11'b11111000000)                              w_dec_class = C_STUR;
    else if ((w_inst == 11'b10001011000) || (w_inst == 11'b11001011000) ||
             (w_inst == 11'b10001010000) || (w_inst == 11'b10101010000)) w_dec_class = C_RTYPE;
    else if (w_inst == 11'b11111111111)                              w_dec_class = C_HALT;
    else if (w_inst[10:1] == 10'b1001000100)                         w_dec_class = C_ADDI;
    else if (w_inst[10:3] == 8'b10110100)                            w_dec_class = C_CBZ;
    else if (w_inst[10:3] == 8'b10110101)                            w_dec_class = C_CBNZ;
    else if (w_inst[10:5] == 6'b000101)                              w_dec_class = C_B;
  end

  // Wait counter defaults to zero so it is cleared on every entry to FETCH/MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_class       <= C_NONE;
      r_wait        <= '0;
      r_retire      <= '0;
      r_halted      <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_wait <= '0;
      case (r_state)
        S_IDLE: if (w_start) r_state <= S_FETCH;
        S_FETCH: begin
          if (w_ack) begin
            r_state <= S_DECODE;
          end else if (w_wait_done) begin
            r_state       <= S_ERROR;
            r_err_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          r_class <= w_dec_class;
          if (w_dec_class == C_NONE) begin
            r_state       <= S_ERROR;
            r_err_illegal <= 1'b1;
          end else if (w_dec_class == C_HALT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_class)
            C_LDUR, C_STUR:  r_state <= S_MEM;
            C_RTYPE, C_ADDI: r_state <= S_WB;
            default: begin
              r_state  <= S_FETCH;
              r_retire <= r_retire + CNT_W'(1);
            end
          endcase
        end
        S_MEM: begin
          if (w_ack) begin
            if (r_class == C_STUR) begin
              r_state  <= S_FETCH;
              r_retire <= r_retire + CNT_W'(1);
            end else begin
              r_state <= S_WB;
            end
          end else if (w_wait_done) begin
            r_state       <= S_ERROR;
            r_err_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_WB: begin
          r_state  <= S_FETCH;
          r_retire <= r_retire + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  logic       w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_pc_sel;
  logic       w_reg_write, w_mem_to_reg, w_reg2loc;
  logic [1:0] w_alu_op, w_alu_src;

  // Strobes decode the state/class registers; only FETCH writes are qualified by ack.
  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_sel     = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg2loc    = 1'b0;
    w_alu_op     = 2'b00;
    w_alu_src    = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        w_ir_write = w_ack;
        w_pc_write = w_ack;
      end
      S_EXEC: begin
        case (r_class)
          C_LDUR: w_alu_src = 2'b01;
          C_STUR: begin
            w_alu_src = 2'b01;
            w_reg2loc = 1'b1;
          end
          C_RTYPE: w_alu_op = 2'b10;
          C_ADDI: begin
            w_alu_op  = 2'b10;
            w_alu_src = 2'b10;
          end
          C_CBZ, C_CBNZ: begin
            w_alu_op   = 2'b01;
            w_reg2loc  = 1'b1;
            w_pc_write = w_taken;
            w_pc_sel   = w_taken;
          end
          C_B: begin
            w_pc_write = 1'b1;
            w_pc_sel   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (r_class == C_STUR);
        w_alu_src = 2'b01;
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (r_class == C_LDUR);
      end
      default: ;
    endcase
  end

  assign bus.mem_req      = w_mem_req;
  assign bus.mem_we       = w_mem_we;
  assign bus.ir_write     = w_ir_write;
  assign bus.pc_write     = w_pc_write;
  assign bus.pc_sel       = w_pc_sel;
  assign bus.reg_write    = w_reg_write;
  assign bus.mem_to_reg   = w_mem_to_reg;
  assign bus.reg2loc      = w_reg2loc;
  assign bus.alu_op       = w_alu_op;
  assign bus.alu_src      = w_alu_src;
  assign bus.state        = r_state;
  assign bus.halted       = r_halted;
  assign bus.err_illegal  = r_err_illegal;
  assign bus.err_timeout  = r_err_timeout;
  assign bus.retire_count = r_retire;

endmodule

// File: tb/tb_cpu_multicycle_sequencer.sv
// Bench for cpu_multicycle_sequencer: a literal vector table, per-instruction
// expected-trace generator, randomized instruction stream and reset/timeout corners.
module tb_cpu_multicycle_sequencer;

  localparam int unsigned CNT_W = 4;
  localparam int          TMO   = 4;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_HALT = 11'b11111111111;

  localparam int K_ILL = 0, K_LDUR = 1, K_STUR = 2, K_RT = 3, K_ADDI = 4;
  localparam int K_CBZ = 5, K_CBNZ = 6, K_B = 7, K_HALT = 8;

  // strb bit order: req, we, ir_write, pc_write, pc_sel, reg_write, mem_to_reg, reg2loc
  // flags bit order: halted, err_illegal, err_timeout
  typedef struct {
    logic        start;
    logic [10:0] inst;
    logic        zero;
    logic        ack;
    logic [2:0]  st;
    logic [7:0]  strb;
    logic [1:0]  aop;
    logic [1:0]  asrc;
    logic [2:0]  flags;
    logic [3:0]  cnt;
  } vec_t;

  logic clk;
  logic rst_n;

  cpu_multicycle_sequencer_if #(.CNT_W(CNT_W)) bus();

  cpu_multicycle_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  m_cnt;
  logic [2:0]  m_flags;
  logic [10:0] cur_op;
  logic        cur_zero;
  vec_t        tbl [14];

  function automatic logic [21:0] dut_out();
    return {bus.state, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.pc_sel,
            bus.reg_write, bus.mem_to_reg, bus.reg2loc, bus.alu_op, bus.alu_src,
            bus.halted, bus.err_illegal, bus.err_timeout, bus.retire_count};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  // Instruction classes straight from the encoding list; exact codes first.
  function automatic int classify(input logic [10:0] op);
    if (op == OP_LDUR) return K_LDUR;
    if (op == OP_STUR) return K_STUR;
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return K_RT;
    if (op == OP_HALT) return K_HALT;
    if (op[10:1] == 10'b1001000100) return K_ADDI;
    if (op[10:3] == 8'b10110100) return K_CBZ;
    if (op[10:3] == 8'b10110101) return K_CBNZ;
    if (op[10:5] == 6'b000101) return K_B;
    return K_ILL;
  endfunction

  function automatic logic [10:0] rand_op(input int k);
    logic [10:0] r;
    r = 11'($urandom);
    case (k)
      0: return OP_LDUR;
      1: return OP_STUR;
      2: return OP_ADD;
      3: return OP_SUB;
      4: return OP_AND;
      5: return OP_ORR;
      6: return {10'b1001000100, r[0]};
      7: return {8'b10110100, r[2:0]};
      8: return {8'b10110101, r[2:0]};
      default: return {6'b000101, r[4:0]};
    endcase
  endfunction

  function automatic vec_t mk(input logic [2:0] st, input logic [7:0] strb,
                              input logic [1:0] aop, input logic [1:0] asrc, input logic ack);
    vec_t v;
    v.start = rnd();
    v.inst  = cur_op;
    v.zero  = cur_zero;
    v.ack   = ack;
    v.st    = st;
    v.strb  = strb;
    v.aop   = aop;
    v.asrc  = asrc;
    v.flags = m_flags;
    v.cnt   = m_cnt;
    return v;
  endfunction

  // Drive one cycle of inputs after the rising edge, compare on the falling edge.
  task automatic step(input vec_t v, input string nm);
    bus.start     = v.start;
    bus.inst31_21 = v.inst;
    bus.alu_zero  = v.zero;
    bus.mem_ack   = v.ack;
    @(negedge clk);
    check(nm, 32'(dut_out()), 32'({v.st, v.strb, v.aop, v.asrc, v.flags, v.cnt}));
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [2:0] st, input string nm);
    for (int i = 0; i < 4; i++) step(mk(st, 8'h00, 2'b00, 2'b00, rnd()), nm);
  endtask

  task automatic idle_start();
    vec_t v;
    v = mk(3'd0, 8'h00, 2'b00, 2'b00, rnd());
    v.start = 1'b0;
    step(v, "idle_hold");
    v = mk(3'd0, 8'h00, 2'b00, 2'b00, rnd());
    v.start = 1'b1;
    step(v, "idle_start");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_cnt   = 4'd0;
    m_flags = 3'b000;
    check("reset_async", 32'(dut_out()), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Expected per-cycle trace of one instruction, starting from the FETCH state.
  task automatic do_instr(input logic [10:0] op, input logic z, input int fd, input int md);
    int         k;
    logic       taken;
    logic [7:0] s;
    cur_op   = op;
    cur_zero = z;
    k        = classify(op);
    for (int i = 0; i < fd && i < TMO; i++) step(mk(3'd1, 8'h80, 2'b00, 2'b00, 1'b0), "fetch_wait");
    if (fd >= TMO) begin
      m_flags[0] = 1'b1;
      hold(3'd7, "fetch_timeout");
      return;
    end
    step(mk(3'd1, 8'hB0, 2'b00, 2'b00, 1'b1), "fetch_ack");
    step(mk(3'd2, 8'h00, 2'b00, 2'b00, rnd()), "decode");
    if (k == K_ILL) begin
      m_flags[1] = 1'b1;
      hold(3'd7, "illegal_hold");
      return;
    end
    if (k == K_HALT) begin
      m_flags[2] = 1'b1;
      hold(3'd6, "halt_hold");
      return;
    end
    case (k)
      K_LDUR: step(mk(3'd3, 8'h00, 2'b00, 2'b01, rnd()), "exec_ldur");
      K_STUR: step(mk(3'd3, 8'h01, 2'b00, 2'b01, rnd()), "exec_stur");
      K_RT:   step(mk(3'd3, 8'h00, 2'b10, 2'b00, rnd()), "exec_rtype");
      K_ADDI: step(mk(3'd3, 8'h00, 2'b10, 2'b10, rnd()), "exec_addi");
      K_CBZ, K_CBNZ: begin
        taken = (k == K_CBZ) ? z : ~z;
        s     = {3'b000, taken, taken, 3'b001};
        step(mk(3'd3, s, 2'b01, 2'b00, rnd()), "exec_cb");
        m_cnt = m_cnt + 4'd1;
        return;
      end
      default: begin
        step(mk(3'd3, 8'h18, 2'b00, 2'b00, rnd()), "exec_b");
        m_cnt = m_cnt + 4'd1;
        return;
      end
    endcase
    if (k == K_LDUR || k == K_STUR) begin
      s = (k == K_STUR) ? 8'hC0 : 8'h80;
      for (int i = 0; i < md && i < TMO; i++) step(mk(3'd4, s, 2'b00, 2'b01, 1'b0), "mem_wait");
      if (md >= TMO) begin
        m_flags[0] = 1'b1;
        hold(3'd7, "mem_timeout");
        return;
      end
      step(mk(3'd4, s, 2'b00, 2'b01, 1'b1), "mem_ack");
      if (k == K_STUR) begin
        m_cnt = m_cnt + 4'd1;
        return;
      end
    end
    step(mk(3'd5, (k == K_LDUR) ? 8'h06 : 8'h04, 2'b00, 2'b00, rnd()), "wb");
    m_cnt = m_cnt + 4'd1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.inst31_21 = 11'd0;
    bus.alu_zero  = 1'b0;
    bus.mem_ack   = 1'b0;
    m_cnt         = 4'd0;
    m_flags       = 3'b000;
    cur_op        = 11'd0;
    cur_zero      = 1'b0;

    // ADD with immediate ack, then LDUR with ack two cycles late in FETCH and MEM.
    tbl[0]  = '{1'b1, OP_ADD,  1'b0, 1'b0, 3'd0, 8'h00, 2'b00, 2'b00, 3'b000, 4'd0};
    tbl[1]  = '{1'b0, OP_ADD,  1'b0, 1'b1, 3'd1, 8'hB0, 2'b00, 2'b00, 3'b000, 4'd0};
    tbl[2]  = '{1'b1, OP_ADD,  1'b0, 1'b1, 3'd2, 8'h00, 2'b00, 2'b00, 3'b000, 4'd0};
    tbl[3]  = '{1'b0, OP_ADD,  1'b0, 1'b0, 3'd3, 8'h00, 2'b10, 2'b00, 3'b000, 4'd0};
    tbl[4]  = '{1'b0, OP_ADD,  1'b0, 1'b0, 3'd5, 8'h04, 2'b00, 2'b00, 3'b000, 4'd0};
    tbl[5]  = '{1'b0, OP_LDUR, 1'b0, 1'b0, 3'd1, 8'h80, 2'b00, 2'b00, 3'b000, 4'd1};
    tbl[6]  = '{1'b1, OP_LDUR, 1'b0, 1'b0, 3'd1, 8'h80, 2'b00, 2'b00, 3'b000, 4'd1};
    tbl[7]  = '{1'b0, OP_LDUR, 1'b0, 1'b1, 3'd1, 8'hB0, 2'b00, 2'b00, 3'b000, 4'd1};
    tbl[8]  = '{1'b0, OP_LDUR, 1'b0, 1'b0, 3'd2, 8'h00, 2'b00, 2'b00, 3'b000, 4'd1};
    tbl[9]  = '{1'b0, OP_LDUR, 1'b1, 1'b0, 3'd3, 8'h00, 2'b00, 2'b01, 3'b000, 4'd1};
    tbl[10] = '{1'b0, OP_LDUR, 1'b0, 1'b0, 3'd4, 8'h80, 2'b00, 2'b01, 3'b000, 4'd1};
    tbl[11] = '{1'b1, OP_LDUR, 1'b0, 1'b0, 3'd4, 8'h80, 2'b00, 2'b01, 3'b000, 4'd1};
    tbl[12] = '{1'b0, OP_LDUR, 1'b0, 1'b1, 3'd4, 8'h80, 2'b00, 2'b01, 3'b000, 4'd1};
    tbl[13] = '{1'b0, OP_LDUR, 1'b0, 1'b0, 3'd5, 8'h06, 2'b00, 2'b00, 3'b000, 4'd1};

    @(posedge clk);
    #1;
    check("reset_outputs", 32'(dut_out()), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) step(tbl[i], $sformatf("tbl_row%0d", i));
    m_cnt = 4'd2;

    // Branch polarity and remaining classes.
    do_instr({8'b10110100, 3'b010}, 1'b1, 0, 0);
    do_instr({8'b10110100, 3'b111}, 1'b0, 1, 0);
    do_instr({8'b10110101, 3'b000}, 1'b0, 0, 0);
    do_instr({8'b10110101, 3'b101}, 1'b1, 2, 0);
    do_instr({6'b000101, 5'b10011}, 1'b0, 0, 0);
    do_instr(OP_STUR, 1'b0, 1, 3);
    do_instr({10'b1001000100, 1'b1}, 1'b0, 3, 0);
    do_instr(OP_SUB, 1'b1, 0, 0);
    do_instr(OP_AND, 1'b0, 0, 0);
    do_instr(OP_ORR, 1'b0, 0, 0);

    for (int n = 0; n < 200; n++)
      do_instr(rand_op(int'($urandom_range(0, 9))), rnd(),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    do_instr(11'b00000000000, 1'b0, 0, 0);

    do_reset();
    idle_start();
    do_instr(OP_ADD, 1'b0, TMO, 0);

    do_reset();
    idle_start();
    do_instr(OP_STUR, 1'b0, 1, TMO);

    // Async reset while a data request is outstanding.
    do_reset();
    idle_start();
    do_instr(OP_ADD, 1'b0, 0, 0);
    cur_op   = OP_LDUR;
    cur_zero = 1'b0;
    step(mk(3'd1, 8'hB0, 2'b00, 2'b00, 1'b1), "pre_reset_fetch");
    step(mk(3'd2, 8'h00, 2'b00, 2'b00, 1'b0), "pre_reset_decode");
    step(mk(3'd3, 8'h00, 2'b00, 2'b01, 1'b0), "pre_reset_exec");
    bus.mem_ack = 1'b0;
    #1;
    check("mem_req_before_reset", 32'(bus.mem_req), 32'd1);
    do_reset();

    idle_start();
    do_instr(OP_HALT, 1'b0, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
